// File: rtl/sync_short_corr_detect.sv
// Short-preamble delayed-autocorrelation detector.
// Forms s[n]*conj(s[n-WIN]) and delayed-sample power, keeps WIN-sample moving sums, and
// runs a plateau FSM that flags detection once |corr| stays above THRESH_Q3/8 of power.
// Optional build macro: SYNC_SHORT_PLATEAU_TOL_EN (tolerate one isolated miss in PLATEAU).
module sync_short_corr_detect #(
    parameter int unsigned I_Q_Width   = 16,
    parameter int unsigned WIN         = 16,
    parameter int unsigned LOG2_WIN    = 4,
    parameter int unsigned ACC_W       = 2 * I_Q_Width + 1 + LOG2_WIN,
    parameter int unsigned THRESH_Q3   = 6,
    parameter int unsigned MIN_PLATEAU = 48
) (
    input  logic                 CLK,
    input  logic                 s_RST,
    input  logic                 enable,
    input  logic                 in_valid,
    input  logic [I_Q_Width-1:0] a_i,
    input  logic [I_Q_Width-1:0] a_q,
    input  logic [I_Q_Width-1:0] a_i_de,
    input  logic [I_Q_Width-1:0] a_q_de,
    output logic [ACC_W-1:0]     corr_i,
    output logic [ACC_W-1:0]     corr_q,
    output logic [ACC_W-1:0]     pwr_sum,
    output logic                 corr_valid,
    output logic                 short_detected,
    output logic                 locked
);

    localparam int unsigned PW   = 2 * I_Q_Width + 1;
    localparam int unsigned CW   = $clog2(MIN_PLATEAU + 1);
    localparam int unsigned WCW  = LOG2_WIN + 1;
    localparam int unsigned CMPW = ACC_W + 4;

    typedef enum logic [1:0] {StIdle, StSearch, StPlateau, StLocked} state_e;

    // Reset and enable-low share one synchronous clear path.
    logic clr;
    assign clr = s_RST || !enable;

    // ---------------- Stage 1: products ----------------
    logic signed [PW-1:0] ai_x, aq_x, di_x, dq_x;
    logic signed [PW-1:0] prod_re_d, prod_im_d;
    logic        [PW-1:0] pwr_d;
    logic signed [PW-1:0] prod_re_q, prod_im_q;
    logic        [PW-1:0] pwr_q;
    logic                 valid1_q;

    assign ai_x      = PW'($signed(a_i));
    assign aq_x      = PW'($signed(a_q));
    assign di_x      = PW'($signed(a_i_de));
    assign dq_x      = PW'($signed(a_q_de));
    assign prod_re_d = ai_x * di_x + aq_x * dq_x;
    assign prod_im_d = aq_x * di_x - ai_x * dq_x;
    assign pwr_d     = di_x * di_x + dq_x * dq_x;

    // Register products only on accepted samples.
    always_ff @(posedge CLK) begin
        if (clr) begin
            valid1_q  <= 1'b0;
            prod_re_q <= '0;
            prod_im_q <= '0;
            pwr_q     <= '0;
        end else begin
            valid1_q <= in_valid;
            if (in_valid) begin
                prod_re_q <= prod_re_d;
                prod_im_q <= prod_im_d;
                pwr_q     <= pwr_d;
            end
        end
    end

    // ---------------- Stage 2: moving sums ----------------
    logic signed [PW-1:0]    buf_re_q [WIN];
    logic signed [PW-1:0]    buf_im_q [WIN];
    logic        [PW-1:0]    buf_pw_q [WIN];
    logic [LOG2_WIN-1:0]     ptr_q;
    logic signed [ACC_W-1:0] sum_re_q, sum_im_q;
    logic        [ACC_W-1:0] sum_pw_q;
    logic [WCW-1:0]          warm_cnt_q;
    logic                    corr_valid_q;

    // Circular window: the slot at ptr_q holds the sample leaving the window.
    always_ff @(posedge CLK) begin
        if (clr) begin
            for (int k = 0; k < WIN; k++) begin
                buf_re_q[k] <= '0;
                buf_im_q[k] <= '0;
                buf_pw_q[k] <= '0;
            end
            ptr_q        <= '0;
            sum_re_q     <= '0;
            sum_im_q     <= '0;
            sum_pw_q     <= '0;
            warm_cnt_q   <= '0;
            corr_valid_q <= 1'b0;
        end else begin
            corr_valid_q <= valid1_q;
            if (valid1_q) begin
                sum_re_q <= sum_re_q + ACC_W'(prod_re_q) - ACC_W'(buf_re_q[ptr_q]);
                sum_im_q <= sum_im_q + ACC_W'(prod_im_q) - ACC_W'(buf_im_q[ptr_q]);
                sum_pw_q <= sum_pw_q + ACC_W'(pwr_q) - ACC_W'(buf_pw_q[ptr_q]);
                buf_re_q[ptr_q] <= prod_re_q;
                buf_im_q[ptr_q] <= prod_im_q;
                buf_pw_q[ptr_q] <= pwr_q;
                ptr_q <= ptr_q + 1'b1;
                if (warm_cnt_q != WCW'(WIN)) begin
                    warm_cnt_q <= warm_cnt_q + 1'b1;
                end
            end
        end
    end

    // ---------------- Stage 3: threshold compare ----------------
    logic [ACC_W-1:0] abs_re, abs_im, mx, mn;
    logic [ACC_W:0]   mag;
    logic [CMPW-1:0]  mag_x8, thr;
    logic             warm_done, above;

    // mag approximates |corr| as max + min/2; compare against power without division.
    always_comb begin
        abs_re    = sum_re_q[ACC_W-1] ? (~sum_re_q + 1'b1) : sum_re_q;
        abs_im    = sum_im_q[ACC_W-1] ? (~sum_im_q + 1'b1) : sum_im_q;
        mx        = (abs_re >= abs_im) ? abs_re : abs_im;
        mn        = (abs_re >= abs_im) ? abs_im : abs_re;
        mag       = {1'b0, mx} + ((ACC_W + 1)'(mn) >> 1);
        mag_x8    = {mag, 3'b000};
        thr       = CMPW'(sum_pw_q) * CMPW'(THRESH_Q3);
        warm_done = (warm_cnt_q == WCW'(WIN));
        above     = warm_done && (sum_pw_q != '0) && (mag_x8 > thr);
    end

    // ---------------- Plateau FSM ----------------
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          det_q, det_d;
`ifdef SYNC_SHORT_PLATEAU_TOL_EN
    logic          miss_q, miss_d;
`endif

    // Next-state: evaluate one compare result per updated sum.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        det_d   = 1'b0;
`ifdef SYNC_SHORT_PLATEAU_TOL_EN
        miss_d  = miss_q;
`endif
        case (state_q)
            StIdle: begin
                if (warm_done) state_d = StSearch;
            end
            StSearch: begin
                if (corr_valid_q && above) begin
                    cnt_d   = CW'(1);
                    state_d = StPlateau;
`ifdef SYNC_SHORT_PLATEAU_TOL_EN
                    miss_d  = 1'b0;
`endif
                end
            end
            StPlateau: begin
                if (corr_valid_q) begin
                    if (above) begin
`ifdef SYNC_SHORT_PLATEAU_TOL_EN
                        miss_d = 1'b0;
`endif
                        if (cnt_q >= CW'(MIN_PLATEAU - 1)) begin
                            cnt_d   = CW'(MIN_PLATEAU);
                            state_d = StLocked;
                            det_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
`ifdef SYNC_SHORT_PLATEAU_TOL_EN
                        if (miss_q) begin
                            cnt_d   = '0;
                            miss_d  = 1'b0;
                            state_d = StSearch;
                        end else begin
                            miss_d = 1'b1;
                        end
`else
                        cnt_d   = '0;
                        state_d = StSearch;
`endif
                    end
                end
            end
            StLocked: begin
                state_d = StLocked;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (clr) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            det_q   <= 1'b0;
`ifdef SYNC_SHORT_PLATEAU_TOL_EN
            miss_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            det_q   <= det_d;
`ifdef SYNC_SHORT_PLATEAU_TOL_EN
            miss_q  <= miss_d;
`endif
        end
    end

    assign corr_i         = sum_re_q;
    assign corr_q         = sum_im_q;
    assign pwr_sum        = sum_pw_q;
    assign corr_valid     = corr_valid_q;
    assign short_detected = det_q;
    assign locked         = (state_q == StLocked);

endmodule

// File: tb/tb_sync_short_corr_detect.sv
// Self-checking bench for sync_short_corr_detect: table of full-window sums plus directed
// sequences (reset latency, correlated/uncorrelated runs, strobe gaps, plateau break,
// enable drop) with a window-sum scoreboard checked on every corr_valid.
module tb_sync_short_corr_detect;

    localparam int ACCW = 37;

    logic            CLK = 1'b0;
    logic            s_RST, enable, in_valid;
    logic [15:0]     a_i, a_q, a_i_de, a_q_de;
    logic [ACCW-1:0] corr_i, corr_q, pwr_sum;
    logic            corr_valid, short_detected, locked;

    sync_short_corr_detect dut (
        .CLK            (CLK),
        .s_RST          (s_RST),
        .enable         (enable),
        .in_valid       (in_valid),
        .a_i            (a_i),
        .a_q            (a_q),
        .a_i_de         (a_i_de),
        .a_q_de         (a_q_de),
        .corr_i         (corr_i),
        .corr_q         (corr_q),
        .pwr_sum        (pwr_sum),
        .corr_valid     (corr_valid),
        .short_detected (short_detected),
        .locked         (locked)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int     ai, aq, di, dq;
        longint ci, cq, pw;
    } vec_t;

    vec_t vecs [5];

    int checks   = 0;
    int failures = 0;

    // Scoreboard: window model and queue of expected sums per accepted sample.
    longint m_re [16];
    longint m_im [16];
    longint m_pw [16];
    int     m_ptr;
    longint s_re, s_im, s_pw;
    longint q_re [$];
    longint q_im [$];
    longint q_pw [$];
    int     cyc, acc_cnt, cv_cnt, det_cnt, det_idx, det_lat;
    int     acc_cyc [256];

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 16; k++) begin
            m_re[k] = 0;
            m_im[k] = 0;
            m_pw[k] = 0;
        end
        m_ptr = 0; s_re = 0; s_im = 0; s_pw = 0;
        q_re.delete(); q_im.delete(); q_pw.delete();
        acc_cnt = 0; cv_cnt = 0; det_cnt = 0; det_idx = -1; det_lat = -1;
    endtask

    // Predict the effect of the coming clock edge from the inputs now applied.
    task automatic model_edge();
        longint ai, aq, di, dq, pr, pi, pp;
        if (s_RST || !enable) begin
            model_clear();
        end else if (in_valid) begin
            ai = longint'($signed(a_i));
            aq = longint'($signed(a_q));
            di = longint'($signed(a_i_de));
            dq = longint'($signed(a_q_de));
            pr = ai * di + aq * dq;
            pi = aq * di - ai * dq;
            pp = di * di + dq * dq;
            s_re = s_re + pr - m_re[m_ptr];
            s_im = s_im + pi - m_im[m_ptr];
            s_pw = s_pw + pp - m_pw[m_ptr];
            m_re[m_ptr] = pr;
            m_im[m_ptr] = pi;
            m_pw[m_ptr] = pp;
            m_ptr = (m_ptr + 1) % 16;
            q_re.push_back(s_re);
            q_im.push_back(s_im);
            q_pw.push_back(s_pw);
            if (acc_cnt < 256) acc_cyc[acc_cnt] = cyc;
            acc_cnt++;
        end
    endtask

    // Outputs sampled at the falling edge after the active edge.
    task automatic observe();
        if (short_detected) begin
            det_cnt++;
            det_idx = cv_cnt - 1;
            det_lat = (det_idx >= 0 && det_idx < 256) ? cyc - acc_cyc[det_idx] : -1;
        end
        if (corr_valid) begin
            if (q_re.size() == 0) begin
                check("sb_unexpected_corr_valid", 1, 0);
            end else begin
                check("sb_corr_i", longint'($signed(corr_i)), q_re.pop_front());
                check("sb_corr_q", longint'($signed(corr_q)), q_im.pop_front());
                check("sb_pwr_sum", longint'(pwr_sum), q_pw.pop_front());
            end
            cv_cnt++;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
        observe();
    endtask

    task automatic do_reset();
        s_RST = 1'b1; in_valid = 1'b0;
        step(); step();
        s_RST = 1'b0;
    endtask

    // mode 0: a=(1000,0); 1: a=0; 2: a alternates +/-1000. Delayed sample always (1000,0).
    task automatic run(input int mode, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            a_i    = (mode == 0) ? 16'sd1000 : (mode == 1) ? 16'sd0 :
                     (i % 2 == 0) ? 16'sd1000 : -16'sd1000;
            a_q    = 16'sd0;
            a_i_de = 16'sd1000;
            a_q_de = 16'sd0;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            for (int g = 1; g < gap; g++) step();
        end
        in_valid = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        vecs[0] = '{ai: 1000, aq: 0, di: 1000, dq: 0,
                    ci: 64'sd16000000, cq: 64'sd0, pw: 64'sd16000000};
        vecs[1] = '{ai: 0, aq: 1000, di: 1000, dq: 0,
                    ci: 64'sd0, cq: 64'sd16000000, pw: 64'sd16000000};
        vecs[2] = '{ai: -300, aq: 200, di: 100, dq: -50,
                    ci: -64'sd640000, cq: 64'sd80000, pw: 64'sd200000};
        vecs[3] = '{ai: -32768, aq: -32768, di: -32768, dq: -32768,
                    ci: 64'sd34359738368, cq: 64'sd0, pw: 64'sd34359738368};
        vecs[4] = '{ai: 32767, aq: -32768, di: -32768, dq: 32767,
                    ci: -64'sd34358689792, cq: 64'sd1048560, pw: 64'sd34358689808};

        cyc = 0;
        model_clear();

        // Reset held with active inputs: everything reads zero.
        s_RST = 1'b1; enable = 1'b1; in_valid = 1'b1;
        a_i = 16'sd1000; a_q = 16'sd500; a_i_de = 16'sd1000; a_q_de = -16'sd200;
        repeat (3) step();
        check("rst_corr_i", longint'(corr_i), 0);
        check("rst_corr_q", longint'(corr_q), 0);
        check("rst_pwr_sum", longint'(pwr_sum), 0);
        check("rst_corr_valid", longint'(corr_valid), 0);
        check("rst_short_detected", longint'(short_detected), 0);
        check("rst_locked", longint'(locked), 0);

        // First post-reset sample: corr_valid two cycles later, for one cycle.
        s_RST = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("cv_latency_1", longint'(corr_valid), 0);
        step();
        check("cv_latency_2", longint'(corr_valid), 1);
        step();
        check("cv_one_cycle", longint'(corr_valid), 0);

        // Table: 16 identical samples fill the window; sums are 16x the product.
        for (int r = 0; r < 5; r++) begin
            do_reset();
            a_i = 16'(vecs[r].ai); a_q = 16'(vecs[r].aq);
            a_i_de = 16'(vecs[r].di); a_q_de = 16'(vecs[r].dq);
            for (int s = 0; s < 16; s++) begin
                in_valid = 1'b1;
                step();
            end
            in_valid = 1'b0;
            repeat (3) step();
            check($sformatf("vec%0d_corr_i", r), longint'($signed(corr_i)), vecs[r].ci);
            check($sformatf("vec%0d_corr_q", r), longint'($signed(corr_q)), vecs[r].cq);
            check($sformatf("vec%0d_pwr_sum", r), longint'(pwr_sum), vecs[r].pw);
            check($sformatf("vec%0d_locked", r), longint'(locked), 0);
        end

        // Correlated, back-to-back: detection on sample 63, 3 cycles after its in_valid.
        do_reset();
        run(0, 80, 1);
        check("corr_det_count", det_cnt, 1);
        check("corr_det_index", det_idx, 63);
        check("corr_det_latency", det_lat, 3);
        check("corr_locked", longint'(locked), 1);

        // Same stimulus with in_valid every 3rd cycle.
        do_reset();
        run(0, 80, 3);
        check("gap_det_count", det_cnt, 1);
        check("gap_det_index", det_idx, 63);
        check("gap_det_latency", det_lat, 3);
        check("gap_locked", longint'(locked), 1);

        // One-cycle enable drop while locked clears everything.
        enable = 1'b0; in_valid = 1'b1;
        step();
        enable = 1'b1; in_valid = 1'b0;
        check("en_drop_locked", longint'(locked), 0);
        check("en_drop_corr_i", longint'(corr_i), 0);
        check("en_drop_pwr_sum", longint'(pwr_sum), 0);
        check("en_drop_corr_valid", longint'(corr_valid), 0);
        run(0, 80, 1);
        check("en_redet_count", det_cnt, 1);
        check("en_redet_index", det_idx, 63);
        check("en_redet_locked", longint'(locked), 1);

        // Uncorrelated: window sum never approaches 0.75 of power.
        do_reset();
        run(2, 64, 1);
        check("uncorr_det_count", det_cnt, 0);
        check("uncorr_locked", longint'(locked), 0);

        // Plateau break: count reaches 43, then breaks; a stale count would lock early.
        do_reset();
        run(0, 56, 1);
        run(1, 16, 1);
        run(0, 40, 1);
        check("break_det_count", det_cnt, 0);
        check("break_locked", longint'(locked), 0);
        // Fresh plateau starts at the 13th resumed sample; 48 of them end at index 131.
        run(0, 21, 1);
        check("break_redet_count", det_cnt, 1);
        check("break_redet_index", det_idx, 131);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
